// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit:
// FSM encoding, forward-select codes, and shadow-stage entry layouts.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  typedef struct packed {
    stage_t     base;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_stage_t;

  function automatic logic writes_reg(stage_t s, logic [4:0] r);
    return s.valid && s.reg_write && (s.dst != 5'd0) && (s.dst == r);
  endfunction

  // MEM holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwd_sel(stage_t mem, stage_t wb, logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (writes_reg(mem, src))
      sel = FWD_MEM;
    else if (writes_reg(wb, src))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_track.sv
// Shadow copy of the EX/MEM/WB pipeline registers; EX takes the ID
// instruction when it advances and a bubble otherwise.
module hazard_track
  import hazard_unit_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_advance,
  input  ex_stage_t i_id,
  output ex_stage_t o_ex,
  output stage_t    o_mem,
  output stage_t    o_wb
);

  ex_stage_t r_ex;
  stage_t    r_mem;
  stage_t    r_wb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex.base;
      r_ex  <= i_advance ? i_id : ex_stage_t'('0);
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_unit.sv
// Stall / flush / forwarding control for a 5-stage pipeline, plus the
// halt drain sequencer.
//   state     | meaning
//   ST_RUN    | normal issue; hazards resolved by priority
//   ST_DRAIN  | halt seen; bubbles while older instructions retire
//   ST_HALTED | pipeline drained; frozen until reset
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rt_used,
  input  logic [4:0] id_dst,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_jump,
  input  logic       id_halt,
  input  logic       ex_branch_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_cnt_nxt;
  logic       w_advance;
  logic       w_load_use;
  ex_stage_t  w_id;
  ex_stage_t  w_ex;
  stage_t     w_mem;
  stage_t     w_wb;

  assign w_id = '{base: '{valid: id_valid, dst: id_dst, reg_write: id_reg_write,
                          mem_read: id_mem_read},
                  rs: id_rs, rt: id_rt};

  hazard_track u_track (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_advance (w_advance),
    .i_id      (w_id),
    .o_ex      (w_ex),
    .o_mem     (w_mem),
    .o_wb      (w_wb)
  );

  assign w_load_use = w_ex.base.valid && w_ex.base.mem_read && (w_ex.base.dst != 5'd0) &&
                      ((w_ex.base.dst == id_rs) || (id_rt_used && (w_ex.base.dst == id_rt)));

  assign fwd_a = fwd_sel(w_mem, w_wb, w_ex.rs);
  assign fwd_b = fwd_sel(w_mem, w_wb, w_ex.rt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_advance       = 1'b0;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    halted          = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else begin
          w_advance = id_valid;
          if (id_valid && id_jump) begin
            ifid_flush = 1'b1;
          end else if (id_valid && id_halt) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = DRAIN_CYCLES;
          end
        end
      end
      ST_DRAIN: begin
        if (ex_branch_taken) begin
          // Halt was on the wrong path; squash it and resume.
          ifid_flush      = 1'b1;
          idex_bubble     = 1'b1;
          w_state_nxt     = ST_RUN;
          w_drain_cnt_nxt = 2'd0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (r_drain_cnt <= 2'd1) begin
            w_state_nxt     = ST_HALTED;
            w_drain_cnt_nxt = 2'd0;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - 2'd1;
          end
        end
      end
      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    // Outputs are combinational, so reset must override them directly.
    if (!reset_n) begin
      w_advance   = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: each stimulus cycle queues its
// hand-computed control word, a negedge monitor pops and compares.
module tb_hazard_unit;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rt_used;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_jump;
  logic       id_halt;
  logic       ex_branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       halted;

  hazard_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rt_used      (id_rt_used),
    .id_dst          (id_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_jump         (id_jump),
    .id_halt         (id_halt),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, halted}
  localparam logic [8:0] NORM     = 9'b1100_00_00_0;
  localparam logic [8:0] STALL    = 9'b0001_00_00_0;
  localparam logic [8:0] BR_FLUSH = 9'b1111_00_00_0;
  localparam logic [8:0] JMP      = 9'b1110_00_00_0;
  localparam logic [8:0] DRAIN    = 9'b0001_00_00_0;
  localparam logic [8:0] HALT     = 9'b0001_00_00_1;
  localparam logic [8:0] FA_WB    = 9'b1100_01_00_0;
  localparam logic [8:0] FAB_MEM  = 9'b1100_10_10_0;
  localparam logic [8:0] FB_MEM   = 9'b1100_00_10_0;
  localparam logic [8:0] FB_WB    = 9'b1100_00_01_0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    logic [8:0] got;
    string      nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, halted};
      n_vec++;
      if (got !== e) begin
        n_miss++;
        $display("FAIL %s: {pc,ifw,flush,bub,fa,fb,halt} got %b expected %b", nm, got, e);
      end
    end
  end

  task automatic idle();
    id_valid        = 1'b0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_rt_used      = 1'b0;
    id_dst          = 5'd0;
    id_reg_write    = 1'b0;
    id_mem_read     = 1'b0;
    id_jump         = 1'b0;
    id_halt         = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic rtu,
                       input logic [4:0] dst, input logic rw, input logic mr);
    idle();
    id_valid     = 1'b1;
    id_rs        = rs;
    id_rt        = rt;
    id_rt_used   = rtu;
    id_dst       = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic step(input logic [8:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step(NORM, "reset");
    reset_n = 1'b1;

    // load-use on rs, then WB forwarding
    issue(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);  step(NORM, "lw8_issue");
    issue(5'd8, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0); step(STALL, "lu_stall");
    issue(5'd8, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0); step(NORM, "lu_release");
    idle();                                     step(FA_WB, "lu_fwd_wb");

    // MEM beats WB
    issue(5'd0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0);  step(NORM, "addi9");
    issue(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);  step(NORM, "add9");
    issue(5'd9, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0); step(NORM, "add11");
    idle();                                     step(FAB_MEM, "fwd_mem_prio");

    // $0 never forwarded
    issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  step(NORM, "addi0");
    issue(5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0); step(NORM, "add_rs0");
    idle();                                     step(NORM, "fwd_r0");

    // taken branch beats load-use
    issue(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);  step(NORM, "lw8_again");
    issue(5'd8, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;                     step(BR_FLUSH, "br_over_lu");
    idle();                                     step(NORM, "br_no_stall");

    // jump, rt_used gating, rt load-use, fwd_b paths
    issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    id_jump = 1'b1;                             step(JMP, "jump_flush");
    issue(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1);  step(NORM, "lw7_issue");
    issue(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);  step(NORM, "rt_unused");
    issue(5'd2, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1);  step(FB_MEM, "fwd_b_mem");
    issue(5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);  step(STALL, "lu_rt");
    issue(5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);  step(NORM, "lu_rt_release");
    idle();                                     step(FB_WB, "fwd_b_wb");

    // halt, drain, absorbing halted
    idle(); id_valid = 1'b1; id_halt = 1'b1;    step(NORM, "halt_issue");
    idle();                                     step(DRAIN, "drain1");
    idle();                                     step(DRAIN, "drain2");
    idle();                                     step(DRAIN, "drain3");
    idle();                                     step(HALT, "halted");
    issue(5'd4, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;                     step(HALT, "halted_abs");
    idle(); reset_n = 1'b0;                     step(NORM, "rst_halted");
    reset_n = 1'b1;                             step(NORM, "post_rst");

    // branch in first drain cycle cancels the halt
    idle(); id_valid = 1'b1; id_halt = 1'b1;    step(NORM, "halt2_issue");
    idle(); ex_branch_taken = 1'b1;             step(BR_FLUSH, "drain_br");
    idle();                                     step(NORM, "drain_br_run");
    idle();                                     step(NORM, "drain_br_run2");

    // reset mid-drain, then fresh issue and forwarding
    idle(); id_valid = 1'b1; id_halt = 1'b1;    step(NORM, "halt3_issue");
    idle();                                     step(DRAIN, "drain_a");
    idle(); reset_n = 1'b0;                     step(NORM, "rst_drain");
    reset_n = 1'b1;
    issue(5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);  step(NORM, "fresh_add");
    issue(5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);  step(NORM, "fresh_dep");
    idle();                                     step(FAB_MEM, "fresh_fwd");

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below in this order.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs, id_rt  in  5 each  source register fields of the ID instruction.
- id_rt_used  in  1  the ID instruction reads rt (R-type, beq/bne, sw).
- id_dst  in  5  destination register, already selected by regDst.
- id_reg_write, id_mem_read, id_jump  in  1 each  control signals decoded for the ID instruction.
- id_halt  in  1  the ID instruction is the all-ones terminating word.
- ex_branch_taken  in  1  the branch now in EX resolved taken.
- pc_write  out  1  the PC may update.
- ifid_write  out  1  the IF/ID register may load.
- ifid_flush  out  1  zero the IF/ID register.
- idex_bubble  out  1  load a NOP into ID/EX (this drives aluSecondSrc[1]).
- fwd_a, fwd_b  out  2 each  operand source for the EX instruction: 00 register file, 01 WB, 10 MEM.
- halted  out  1  the pipeline has drained after a halt.

Function
REQ-002 The block SHALL keep shadow entries EX, MEM and WB; each entry holds {valid, dst, reg_write, mem_read}, and the EX entry also holds rs and rt.
REQ-003 On every clock edge the block SHALL shift WB<=MEM and MEM<=EX.
REQ-004 On every clock edge EX SHALL load the ID fields if the ID instruction advances, and otherwise SHALL load an invalid bubble.
REQ-005 The ID instruction SHALL advance only when all of the following hold: id_valid=1, no stall, no flush, and state=RUN.
REQ-006 A load-use hazard SHALL be detected when all of the following hold: EX.valid, EX.mem_read, EX.dst!=0, and EX.dst equals id_rs, or equals id_rt with id_rt_used=1.
REQ-007 On a load-use hazard the block SHALL drive pc_write=0, ifid_write=0 and idex_bubble=1 for exactly one cycle; the condition then clears because EX holds the bubble.
REQ-008 On ex_branch_taken=1 the block SHALL drive ifid_flush=1, idex_bubble=1 and pc_write=1, removing the two younger instructions.
REQ-009 On id_jump=1 with id_valid=1 the block SHALL drive ifid_flush=1 for one cycle while the jump itself advances.
REQ-010 When events coincide, the block SHALL apply this priority: ex_branch_taken, then load-use stall, then jump, then halt.
REQ-011 Forwarding SHALL be combinational from the registered entries.
- fwd_a=10 if MEM.valid, MEM.reg_write, MEM.dst!=0 and MEM.dst==EX.rs.
- Otherwise fwd_a=01 if the same conditions hold on WB.
- Otherwise fwd_a=00.
- fwd_b follows the same rule using EX.rt.
- MEM SHALL take priority over WB.
- Register 0 SHALL never be forwarded.
REQ-012 The state machine SHALL have the states RUN, DRAIN and HALTED.
REQ-013 From RUN, the block SHALL move to DRAIN when id_halt=1 and id_valid=1, with no higher-priority event, and SHALL load drain_cnt=3.
REQ-014 In DRAIN the block SHALL hold pc_write=0, ifid_write=0 and idex_bubble=1, and SHALL decrement drain_cnt by 1 each cycle.
REQ-015 In DRAIN, when drain_cnt reaches 0, the block SHALL go to HALTED.
REQ-016 In DRAIN, ex_branch_taken=1 SHALL discard the halt, apply REQ-008, and return the block to RUN.
REQ-017 HALTED SHALL be absorbing until reset, with halted=1, pc_write=0 and ifid_write=0.
REQ-018 With no event, the block SHALL drive pc_write=1, ifid_write=1, ifid_flush=0 and idex_bubble=0.
REQ-019 The block SHALL have zero-cycle latency from hazard detection to its control outputs.

Reset
REQ-020 While reset_n=0, all shadow entries SHALL be invalid, state=RUN, drain_cnt=0, pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00 and halted=0.
REQ-021 Reset asserted mid-stall or mid-drain SHALL take effect immediately, with no pending flush retained.

Structure
REQ-022 The shared package SHALL hold the state encoding, the forward-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and DRAIN_CYCLES=3.
REQ-023 The shadow pipeline SHALL be one sub-module, hazard_track, instantiated once; the stall, flush and forwarding logic SHALL live in hazard_unit.

Verification
REQ-024 The bench SHALL cover at least the following directed scenarios:
- lw $8 in EX, then add with rs=8 in ID -> exactly one cycle with pc_write=0, ifid_write=0, idex_bubble=1; the next cycle shows fwd_a=01 once the lw reaches WB.
- add $9 in MEM and addi $9 in WB, EX instruction with rs=9 -> fwd_a=10 (MEM takes priority).
- Destination $0 in MEM with EX rs=0 -> fwd_a=00.
- ex_branch_taken=1 in the same cycle as a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_write=1, and no stall cycle.
- id_halt=1 -> 3 drain cycles, then halted=1 held; a variant with ex_branch_taken=1 in drain cycle 1 -> back to RUN with halted=0.
- reset_n pulsed low during DRAIN -> all outputs at their reset values immediately; a fresh add then issues normally.
